// File: rtl/bus_pkg.sv
// Shared bus definitions used by every master/slave on the system bus.
package bus_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_t;

endpackage

// File: rtl/fetch_pkg.sv
// Types and constants for the instruction fetch / prefetch buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Read-side bus between the fetch master and the instruction ROM slave.
interface fetch_prefetch_buffer_if;
    import bus_pkg::*;

    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_write;
    tsize_t      bus_tsize;
    logic [31:0] bus_rdata;
    logic        bus_bdone;
    logic        bus_rerror;

    modport master (
        output bus_req, bus_addr, bus_write, bus_tsize,
        input  bus_rdata, bus_bdone, bus_rerror
    );

    modport slave (
        input  bus_req, bus_addr, bus_write, bus_tsize,
        output bus_rdata, bus_bdone, bus_rerror
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with single-cycle flush; head is read combinationally.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rptr;
    logic [AW-1:0]  wptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count != '0);
    // A push at full is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count < FULL) || do_pop);
    assign head    = mem[rptr];

    // Storage is reset so the head fields read as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Fetch stage: streams sequential ROM words into a prefetch FIFO for decode,
// restarting on redirect and discarding any read already on the bus.
module fetch_prefetch_buffer
    import fetch_pkg::*;
    import bus_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_pc,
    output logic                            instr_valid,
    input  logic                            instr_ready,
    output logic [31:0]                     instr_data,
    output logic [31:0]                     instr_pc,
    output logic                            instr_fault,
    fetch_prefetch_buffer_if.master         bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   kill_addr;
    logic          live;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  wentry;
    logic          done;
    logic          push;
    logic          pop;

    // live holds the bus idle for the first cycle after reset release, so
    // bus_req is low throughout reset even though state resets to RUN.
    assign bus.bus_req   = live && (((state == RUN) && (count < FULL)) || (state == KILL));
    assign bus.bus_addr  = (state == KILL) ? kill_addr : fetch_pc;
    assign bus.bus_write = 1'b0;
    assign bus.bus_tsize = WORD;

    assign done   = bus.bus_req && bus.bus_bdone;
    assign push   = done && (state == RUN) && !redirect_valid;
    assign pop    = instr_valid && instr_ready && !redirect_valid;
    assign wentry = '{pc: fetch_pc, data: bus.bus_rdata, fault: bus.bus_rerror};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .head  (head),
        .count (count)
    );

    assign instr_valid = (count != '0);
    assign instr_data  = head.data;
    assign instr_pc    = head.pc;
    assign instr_fault = head.fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            kill_addr <= '0;
            live      <= 1'b0;
        end else begin
            live <= 1'b1;
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
                case (state)
                    // A read still waiting on the slave must be let finish
                    // at its original address; its data is thrown away.
                    RUN: begin
                        if (bus.bus_req && !bus.bus_bdone) begin
                            state     <= KILL;
                            kill_addr <= fetch_pc;
                        end else begin
                            state <= RUN;
                        end
                    end
                    KILL:    state <= KILL;
                    default: state <= RUN;
                endcase
            end else begin
                case (state)
                    RUN: begin
                        if (done) begin
                            fetch_pc <= fetch_pc + PC_STEP;
                            if (bus.bus_rerror) state <= HALT;
                        end
                    end
                    KILL: begin
                        if (done) state <= RUN;
                    end
                    HALT:    state <= HALT;
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: ROM slave with variable latency, queue-based
// reference model checked every cycle, plus directed literal checks.
module tb_fetch_prefetch_buffer;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_fault;

    always #5 clk = ~clk;

    fetch_prefetch_buffer_if bif ();

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault),
        .bus            (bif)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- ROM slave with programmable wait states
    int          lat = 0;
    int          sw = 0;
    int          ndone = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic        rnd_err = 1'b0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bif.bus_bdone  = bif.bus_req && (sw >= lat);
    assign bif.bus_rdata  = rom(bif.bus_addr);
    assign bif.bus_rerror = (err_en && (bif.bus_addr == err_addr)) || rnd_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sw <= 0;
        else if (bif.bus_req && bif.bus_bdone) begin
            sw    <= 0;
            ndone <= ndone + 1;
        end else if (bif.bus_req) sw <= sw + 1;
        else sw <= 0;
    end

    // ---------------- reference model: queue of fetched words, a fetch mode
    // (0 fetching, 1 stopped on error, 2 discarding a stale read)
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        f;
    } ent_t;

    ent_t        mq[$];
    int          mmode = 0;
    logic [31:0] mpc = '0;
    logic [31:0] mkill = '0;
    bit          mlive = 0;
    bit          m_rq, m_bd, m_er, m_pop;
    logic [31:0] m_a;

    function automatic bit m_req();
        return mlive && (((mmode == 0) && (mq.size() < 4)) || (mmode == 2));
    endfunction

    function automatic logic [31:0] m_addr();
        return (mmode == 2) ? mkill : mpc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mmode = 0;
            mpc   = 32'h0;
            mkill = 32'h0;
            mlive = 0;
        end else begin
            m_rq  = m_req();
            m_a   = m_addr();
            m_bd  = m_rq && (sw >= lat);
            m_er  = (err_en && (m_a == err_addr)) || rnd_err;
            m_pop = (mq.size() != 0) && instr_ready && !redirect_valid;
            if (redirect_valid) begin
                mq.delete();
                if (mmode == 0 && m_rq && !m_bd) begin
                    mmode = 2;
                    mkill = mpc;
                end else if (mmode != 2) begin
                    mmode = 0;
                end
                mpc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_bd && mmode == 0) begin
                    mq.push_back('{mpc, rom(mpc), m_er});
                    mpc = mpc + 32'd4;
                    if (m_er) mmode = 1;
                end else if (m_bd && mmode == 2) begin
                    mmode = 0;
                end
            end
            mlive = 1;
        end
    end

    // ---------------- per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_bus_req", {31'b0, bif.bus_req}, 32'd0);
            chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
            chk("rst_instr_data", instr_data, 32'd0);
            chk("rst_instr_pc", instr_pc, 32'd0);
            chk("rst_instr_fault", {31'b0, instr_fault}, 32'd0);
        end else begin
            chk("bus_req", {31'b0, bif.bus_req}, {31'b0, m_req()});
            if (m_req()) chk("bus_addr", bif.bus_addr, m_addr());
            chk("bus_write", {31'b0, bif.bus_write}, 32'd0);
            chk("bus_tsize", {30'b0, bif.bus_tsize}, 32'd2);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("instr_pc", instr_pc, mq[0].pc);
                chk("instr_data", instr_data, mq[0].data);
                chk("instr_fault", {31'b0, instr_fault}, {31'b0, mq[0].f});
            end
        end
    end

    // ---------------- delivered-stream monitor
    logic [31:0] gotpc[$];
    logic        gotf[$];

    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            gotpc.push_back(instr_pc);
            gotf.push_back(instr_fault);
        end
    end

    function automatic logic [31:0] qpc(input int i);
        return (gotpc.size() > i) ? gotpc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qf(input int i);
        return (gotf.size() > i) ? {31'b0, gotf[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        tick();
        redirect_valid = 1'b0;
        gotpc.delete();
        gotf.delete();
    endtask

    int          n0;
    bit          found;
    logic [31:0] held;

    initial begin
        instr_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_bus_req", {31'b0, bif.bus_req}, 32'd0);
        chk("reset_valid", {31'b0, instr_valid}, 32'd0);

        // streaming from reset
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        chk("t1_req", {31'b0, bif.bus_req}, 32'd1);
        chk("t1_addr0", bif.bus_addr, 32'h0);
        chk("t1_valid0", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("t1_addr1", bif.bus_addr, 32'h4);
        chk("t1_valid1", {31'b0, instr_valid}, 32'd1);
        chk("t1_pc0", instr_pc, 32'h0);
        chk("t1_data0", instr_data, 32'h5A5A_0F0F);
        tick();
        chk("t1_addr2", bif.bus_addr, 32'h8);
        chk("t1_pc1", instr_pc, 32'h4);
        repeat (5) tick();

        // asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, bif.bus_req}, 32'd0);
        chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_rst_pc", instr_pc, 32'd0);
        chk("async_rst_data", instr_data, 32'd0);
        tick();
        instr_ready = 1'b0;
        gotpc.delete();
        gotf.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        n0 = ndone;

        // decode stalled: FIFO fills with exactly DEPTH words
        repeat (10) tick();
        chk("stall_pushes", ndone - n0, 32'd4);
        chk("stall_req", {31'b0, bif.bus_req}, 32'd0);
        chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        chk("stall_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 8; i++) chk("stream_pc", qpc(i), 32'(4 * i));

        // redirect with a full FIFO
        instr_ready = 1'b0;
        repeat (6) tick();
        chk("full_req", {31'b0, bif.bus_req}, 32'd0);
        redirect_to(32'h0000_0102);
        chk("redir_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_req", {31'b0, bif.bus_req}, 32'd1);
        chk("redir_addr", bif.bus_addr, 32'h100);
        instr_ready = 1'b1;
        repeat (5) tick();
        chk("redir_first", qpc(0), 32'h100);
        chk("redir_second", qpc(1), 32'h104);

        // slow slave, redirect during the first wait cycle
        lat = 3;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bif.bus_bdone) found = 1;
        end
        chk("slow_bdone_seen", {31'b0, found}, 32'd1);
        @(posedge clk); #1;
        held = bif.bus_addr;
        redirect_to(32'h0000_2000);
        chk("kill_req", {31'b0, bif.bus_req}, 32'd1);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            chk("kill_addr_hold", bif.bus_addr, held);
            if (bif.bus_bdone) found = 1;
            tick();
        end
        chk("kill_bdone_seen", {31'b0, found}, 32'd1);
        chk("kill_next_addr", bif.bus_addr, 32'h2000);
        for (int k = 0; k < 30 && gotpc.size() == 0; k++) tick();
        chk("kill_first_pc", qpc(0), 32'h2000);

        // bus error on 0x8
        lat = 0;
        err_en = 1'b1;
        err_addr = 32'h8;
        redirect_to(32'h0);
        repeat (10) tick();
        chk("err_count", gotpc.size(), 32'd3);
        chk("err_pc", qpc(2), 32'h8);
        chk("err_fault", qf(2), 32'd1);
        chk("err_prev_fault", qf(1), 32'd0);
        chk("err_halt_req", {31'b0, bif.bus_req}, 32'd0);
        err_en = 1'b0;
        redirect_to(32'h40);
        repeat (5) tick();
        chk("err_resume", qpc(0), 32'h40);

        // address wrap at the top of memory
        redirect_to(32'hFFFF_FFFE);
        repeat (5) tick();
        chk("wrap_top", qpc(0), 32'hFFFF_FFFC);
        chk("wrap_zero", qpc(1), 32'h0);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            rnd_err        = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 2);
            tick();
        end
        redirect_valid = 1'b0;
        rnd_err = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
